fetch_pc_gen: RTL and testbench
===============================

# fetch_pc_gen

Parametrised superscalar fetch-address generator, successor to the single-issue PC incrementer. Each cycle it presents an aligned group of FETCH_WIDTH word addresses with per-slot valid bits to the instruction-memory/fetch stage. It supports stall (hold), one-cycle-latency redirect from branch/jump resolution, halt, and a count of issued fetch groups. It sits at the head of the pipeline, ahead of the IF/ID register.

## Interface
- PC_START, 32'h00400020: fetch address after reset; need not be group-aligned.
- ADDR_W, 32: address width.
- FETCH_WIDTH, 4: instructions per group; power of two in {1,2,4,8}.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; highest priority.
- load_pc  in  1  1 = downstream accepts the current group and PC advances; 0 = hold (stall).
- redirect_valid  in  1  branch/jump redirect request.
- redirect_pc  in  ADDR_W  redirect target; bits [1:0] ignored and treated as 0.
- halt  in  1  stop fetching after the current group.
- fetch_addr  out  FETCH_WIDTH*ADDR_W  slot i at [i*ADDR_W +: ADDR_W].
- fetch_valid  out  FETCH_WIDTH  bit i = slot i valid.
- halted  out  1  1 while in HALT.
- group_count  out  32  number of groups issued since reset.

## Operation
- Internal: pc_q (word-aligned ADDR_W), state in {BOOT, RUN, HALT}, group_count.
- GB = 4*FETCH_WIDTH bytes. base = pc_q with low log2(GB) bits cleared. off = pc_q[log2(GB)-1:2].
- fetch_addr slot i = base + 4*i, modulo 2^ADDR_W. Always driven, independent of state.
- fetch_valid bit i = (state == RUN) && (i >= off). BOOT and HALT force all zeros.
- issue = (state == RUN) && load_pc && !redirect_valid. On issue, group_count increments, wrapping at 2^32.
- Next pc_q, in priority order:
  - reset: PC_START with bits [1:0] cleared.
  - redirect_valid: {redirect_pc[ADDR_W-1:2], 2'b00}.
  - issue: base + GB, wrapping modulo 2^ADDR_W.
  - otherwise: hold.
- State transitions:
  - reset: BOOT.
  - BOOT: RUN next cycle, unconditionally. A redirect in BOOT loads pc_q.
  - RUN: HALT if halt && !redirect_valid, otherwise stay in RUN. If halt && load_pc, the group is still issued and counted, and the PC advances.
  - HALT: RUN on redirect_valid; otherwise hold, ignoring load_pc and halt.
- Simultaneous events:
  - Redirect beats halt and load_pc. The current group is discarded and not counted.
  - Redirect with load_pc=0 is still taken.
  - Reset mid-operation discards everything and restores the reset values.

## Timing
- Outputs are combinational from registers only; no input-to-output combinational path.
- Redirect latency: 1 cycle. A redirect sampled at edge N makes fetch_addr show the target group from cycle N+1.
- After reset deasserts: one BOOT cycle with fetch_valid=0, then the first valid group.
- Reset values:
  - fetch_valid=0, halted=0, group_count=0.
  - fetch_addr reflects aligned PC_START (32'h00400020, W=4: 0x00400020/24/28/2C).
- Stall: with load_pc=0 in RUN, fetch_addr and fetch_valid are held stable indefinitely.
- halted asserts the cycle after halt is sampled, and deasserts the cycle after a redirect.

## Test plan
- **Reset/boot:** defaults; reset=1 for 1 cycle, then load_pc=1. Expect:
  - BOOT cycle: valid=4'b0000.
  - Next cycle: slots 0x00400020..2C, valid=4'b1111.
  - Next cycle: 0x00400030.., group_count=1.
- **Stall/resume:** load_pc=0 for 3 cycles, then 1. Expect fetch_addr held and group_count unchanged while stalled; PC advances by 0x10 on the first cycle with load_pc=1.
- **Unaligned redirect:** redirect_pc=0x00400037. Expect:
  - Next cycle: base 0x00400030, valid=4'b1110.
  - Following group: 0x00400040 with valid=4'b1111.
- **Halt/priority:**
  - halt=1 with load_pc=1: group counted, then halted=1 and valid=0 regardless of load_pc.
  - halt and redirect_valid together in RUN: redirect wins and halted stays 0.
  - Redirect to 0x00400100 from HALT resumes there.
- **Wrap and width:** FETCH_WIDTH=2, redirect to 0xFFFFFFF8. Expect slots 0xFFFFFFF8/0xFFFFFFFC, then 0x00000000/0x00000004.
- **Mid-run reset:** assert reset during RUN with pending redirect and halt. Expect next cycle BOOT, PC_START, group_count=0, halted=0.

Source files
------------

// File: rtl/fetch_pc_gen_if.sv
// Fetch-address bus between the PC generator and the fetch stage.
// The master side issues accept/redirect/halt; the slave side presents the group.
interface fetch_pc_gen_if #(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned FETCH_WIDTH = 4
);
   logic                            load_pc;
   logic                            redirect_valid;
   logic [ADDR_W-1:0]               redirect_pc;
   logic                            halt;
   logic [FETCH_WIDTH*ADDR_W-1:0]   fetch_addr;
   logic [FETCH_WIDTH-1:0]          fetch_valid;
   logic                            halted;
   logic [31:0]                     group_count;

   modport master (
      output load_pc, redirect_valid, redirect_pc, halt,
      input  fetch_addr, fetch_valid, halted, group_count
   );

   modport slave (
      input  load_pc, redirect_valid, redirect_pc, halt,
      output fetch_addr, fetch_valid, halted, group_count
   );
endinterface

// File: rtl/fetch_pc_gen.sv
// Superscalar fetch-address generator: presents an aligned group of
// FETCH_WIDTH word addresses per cycle with per-slot valid bits, and
// supports stall, one-cycle redirect, halt and an issued-group counter.
module fetch_pc_gen #(
   parameter int unsigned       ADDR_W      = 32,
   parameter int unsigned       FETCH_WIDTH = 4,
   parameter logic [ADDR_W-1:0] PC_START    = ADDR_W'(32'h00400020)
) (
   input logic           clk,
   input logic           reset,
   fetch_pc_gen_if.slave bus
);

   // Group size in bytes; mask selects the within-group byte offset.
   localparam int unsigned       GB      = 4 * FETCH_WIDTH;
   localparam logic [ADDR_W-1:0] GB_MASK = ADDR_W'(GB - 1);
   localparam logic [ADDR_W-1:0] WORD_MASK = ADDR_W'(3);

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_d;
   logic [31:0]       count_q;
   logic [31:0]       count_d;
   logic [ADDR_W-1:0] base_s;
   logic [ADDR_W-1:0] off_s;
   logic              issue_s;

   assign base_s  = pc_q & ~GB_MASK;
   assign off_s   = (pc_q & GB_MASK) >> 2;
   assign issue_s = (state_q == ST_RUN) && bus.load_pc && !bus.redirect_valid;

   // Next PC and group counter: redirect beats issue, otherwise hold.
   always_comb begin
      pc_d    = pc_q;
      count_d = count_q;
      if (bus.redirect_valid) begin
         pc_d = bus.redirect_pc & ~WORD_MASK;
      end else if (issue_s) begin
         pc_d = base_s + ADDR_W'(GB);
      end else begin
         pc_d = pc_q;
      end
      if (issue_s) begin
         count_d = count_q + 32'd1;
      end else begin
         count_d = count_q;
      end
   end

   // State register, PC and counter; reset wins over everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_BOOT;
         pc_q    <= PC_START & ~WORD_MASK;
         count_q <= 32'd0;
      end else begin
         pc_q    <= pc_d;
         count_q <= count_d;
         case (state_q)
            ST_BOOT: state_q <= ST_RUN;
            ST_RUN: begin
               if (bus.halt && !bus.redirect_valid) begin
                  state_q <= ST_HALT;
               end else begin
                  state_q <= ST_RUN;
               end
            end
            ST_HALT: begin
               if (bus.redirect_valid) begin
                  state_q <= ST_RUN;
               end else begin
                  state_q <= ST_HALT;
               end
            end
            default: state_q <= ST_BOOT;
         endcase
      end
   end

   // Slot addresses are always driven; slots before the entry offset are invalid.
   always_comb begin
      bus.fetch_addr  = '0;
      bus.fetch_valid = '0;
      for (int i = 0; i < int'(FETCH_WIDTH); i++) begin
         bus.fetch_addr[i*ADDR_W +: ADDR_W] = base_s + ADDR_W'(4 * i);
         bus.fetch_valid[i] = (state_q == ST_RUN) && (ADDR_W'(i) >= off_s);
      end
   end

   assign bus.halted      = (state_q == ST_HALT);
   assign bus.group_count = count_q;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Self-checking bench for fetch_pc_gen: a FETCH_WIDTH=4 and a FETCH_WIDTH=2
// instance share stimulus; a directed vector table, a wrap sequence and
// random cycles are checked against an arithmetic reference model.
module tb_fetch_pc_gen;

   logic        clk = 1'b0;
   logic        reset;
   logic        load_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   fetch_pc_gen_if #(.ADDR_W(32), .FETCH_WIDTH(4)) if0 ();
   fetch_pc_gen_if #(.ADDR_W(32), .FETCH_WIDTH(2)) if1 ();

   assign if0.load_pc        = load_pc;
   assign if0.redirect_valid = redirect_valid;
   assign if0.redirect_pc    = redirect_pc;
   assign if0.halt           = halt;
   assign if1.load_pc        = load_pc;
   assign if1.redirect_valid = redirect_valid;
   assign if1.redirect_pc    = redirect_pc;
   assign if1.halt           = halt;

   fetch_pc_gen #(.ADDR_W(32), .FETCH_WIDTH(4), .PC_START(32'h00400020)) u_dut4 (
      .clk(clk), .reset(reset), .bus(if0.slave));
   fetch_pc_gen #(.ADDR_W(32), .FETCH_WIDTH(2), .PC_START(32'h00400020)) u_dut2 (
      .clk(clk), .reset(reset), .bus(if1.slave));

   // ---------------- reference model ----------------
   localparam int M_BOOT = 0;
   localparam int M_RUN  = 1;
   localparam int M_HALT = 2;

   logic [31:0] m_pc  [2];
   int          m_st  [2];
   logic [31:0] m_cnt [2];

   function automatic logic [31:0] fw_of(int k);
      return (k == 0) ? 32'd4 : 32'd2;
   endfunction

   task automatic model_edge();
      for (int k = 0; k < 2; k++) begin
         logic [31:0] gb;
         logic [31:0] base;
         logic        iss;
         gb   = 32'd4 * fw_of(k);
         base = (m_pc[k] / gb) * gb;
         iss  = (m_st[k] == M_RUN) && load_pc && !redirect_valid;
         if (reset) begin
            m_pc[k]  = 32'h00400020;
            m_st[k]  = M_BOOT;
            m_cnt[k] = 32'd0;
         end else begin
            if (redirect_valid) m_pc[k] = (redirect_pc / 32'd4) * 32'd4;
            else if (iss)       m_pc[k] = base + gb;
            if (iss) m_cnt[k] = m_cnt[k] + 32'd1;
            if (m_st[k] == M_BOOT)      m_st[k] = M_RUN;
            else if (m_st[k] == M_RUN)  m_st[k] = (halt && !redirect_valid) ? M_HALT : M_RUN;
            else                        m_st[k] = redirect_valid ? M_RUN : M_HALT;
         end
      end
   endtask

   task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic check_model();
      for (int k = 0; k < 2; k++) begin
         logic [127:0] ea;
         logic [7:0]   ev;
         logic [31:0]  gb;
         logic [31:0]  base;
         logic [31:0]  off;
         logic [127:0] aa;
         logic [7:0]   av;
         logic         ah;
         logic [31:0]  ac;
         gb   = 32'd4 * fw_of(k);
         base = (m_pc[k] / gb) * gb;
         off  = (m_pc[k] % gb) / 32'd4;
         ea   = '0;
         ev   = '0;
         for (int i = 0; i < int'(fw_of(k)); i++) begin
            ea[i*32 +: 32] = base + 32'(4 * i);
            ev[i] = (m_st[k] == M_RUN) && (32'(i) >= off);
         end
         if (k == 0) begin
            aa = 128'(if0.fetch_addr); av = 8'(if0.fetch_valid);
            ah = if0.halted; ac = if0.group_count;
         end else begin
            aa = 128'(if1.fetch_addr); av = 8'(if1.fetch_valid);
            ah = if1.halted; ac = if1.group_count;
         end
         chk($sformatf("model addr w%0d", fw_of(k)), aa, ea);
         chk($sformatf("model valid w%0d", fw_of(k)), 128'(av), 128'(ev));
         chk($sformatf("model halted w%0d", fw_of(k)), 128'(ah), 128'(m_st[k] == M_HALT));
         chk($sformatf("model count w%0d", fw_of(k)), 128'(ac), 128'(m_cnt[k]));
      end
   endtask

   // one clock: model follows the edge, outputs sampled 1 time unit later
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_model();
   endtask

   task automatic drive(logic r, logic ld, logic rv, logic [31:0] rp, logic hl);
      reset = r; load_pc = ld; redirect_valid = rv; redirect_pc = rp; halt = hl;
   endtask

   // ---------------- directed vector table (FETCH_WIDTH=4) ----------------
   typedef struct {
      logic        rst;
      logic        ld;
      logic        rv;
      logic [31:0] rpc;
      logic        hl;
      logic [31:0] a0;
      logic [3:0]  v;
      logic        h;
      logic [31:0] c;
   } vec_t;

   function automatic vec_t mk(logic rst, logic ld, logic rv, logic [31:0] rpc, logic hl,
                               logic [31:0] a0, logic [3:0] v, logic h, logic [31:0] c);
      vec_t t;
      t.rst = rst; t.ld = ld; t.rv = rv; t.rpc = rpc; t.hl = hl;
      t.a0 = a0; t.v = v; t.h = h; t.c = c;
      return t;
   endfunction

   vec_t tbl [19];

   initial begin
      tbl[0]  = mk(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h00400020, 4'b0000, 1'b0, 32'd0);
      tbl[1]  = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h00400020, 4'b1111, 1'b0, 32'd0);
      tbl[2]  = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h00400030, 4'b1111, 1'b0, 32'd1);
      tbl[3]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h00400030, 4'b1111, 1'b0, 32'd1);
      tbl[4]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h00400030, 4'b1111, 1'b0, 32'd1);
      tbl[5]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h00400030, 4'b1111, 1'b0, 32'd1);
      tbl[6]  = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h00400040, 4'b1111, 1'b0, 32'd2);
      tbl[7]  = mk(1'b0, 1'b1, 1'b1, 32'h00400037, 1'b0, 32'h00400030, 4'b1110, 1'b0, 32'd2);
      tbl[8]  = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h00400040, 4'b1111, 1'b0, 32'd3);
      tbl[9]  = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h00400050, 4'b0000, 1'b1, 32'd4);
      tbl[10] = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h00400050, 4'b0000, 1'b1, 32'd4);
      tbl[11] = mk(1'b0, 1'b0, 1'b1, 32'h00400100, 1'b0, 32'h00400100, 4'b1111, 1'b0, 32'd4);
      tbl[12] = mk(1'b0, 1'b1, 1'b1, 32'h00400200, 1'b1, 32'h00400200, 4'b1111, 1'b0, 32'd4);
      tbl[13] = mk(1'b1, 1'b1, 1'b1, 32'h00400300, 1'b1, 32'h00400020, 4'b0000, 1'b0, 32'd0);
      tbl[14] = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h00400020, 4'b1111, 1'b0, 32'd0);
      tbl[15] = mk(1'b0, 1'b0, 1'b1, 32'h00400108, 1'b0, 32'h00400100, 4'b1100, 1'b0, 32'd0);
      tbl[16] = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h00400110, 4'b1111, 1'b0, 32'd1);
      tbl[17] = mk(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h00400020, 4'b0000, 1'b0, 32'd0);
      tbl[18] = mk(1'b0, 1'b1, 1'b1, 32'h00400044, 1'b0, 32'h00400040, 4'b1110, 1'b0, 32'd0);

      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

      for (int n = 0; n < 19; n++) begin
         drive(tbl[n].rst, tbl[n].ld, tbl[n].rv, tbl[n].rpc, tbl[n].hl);
         step();
         chk($sformatf("tbl[%0d] slot0", n), 128'(if0.fetch_addr[31:0]), 128'(tbl[n].a0));
         chk($sformatf("tbl[%0d] slot3", n), 128'(if0.fetch_addr[127:96]), 128'(tbl[n].a0 + 32'd12));
         chk($sformatf("tbl[%0d] valid", n), 128'(if0.fetch_valid), 128'(tbl[n].v));
         chk($sformatf("tbl[%0d] halted", n), 128'(if0.halted), 128'(tbl[n].h));
         chk($sformatf("tbl[%0d] count", n), 128'(if0.group_count), 128'(tbl[n].c));
      end

      // address wrap on the two-wide instance
      drive(1'b0, 1'b1, 1'b1, 32'hFFFFFFF8, 1'b0);
      step();
      chk("wrap w2 addr pre", 128'(if1.fetch_addr), 128'({32'hFFFFFFFC, 32'hFFFFFFF8}));
      chk("wrap w2 valid pre", 128'(if1.fetch_valid), 128'(2'b11));
      chk("wrap w4 valid pre", 128'(if0.fetch_valid), 128'(4'b1100));
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      step();
      chk("wrap w2 addr post", 128'(if1.fetch_addr), 128'({32'h00000004, 32'h00000000}));
      chk("wrap w2 valid post", 128'(if1.fetch_valid), 128'(2'b11));
      chk("wrap w4 addr post", 128'(if0.fetch_addr[31:0]), 128'(32'h00000000));

      // randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         drive(($urandom_range(0, 49) == 0),
               ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 7) == 0),
               (($urandom_range(0, 3) == 0) ? (32'hFFFFFFC0 | 32'($urandom_range(0, 63)))
                                            : $urandom),
               ($urandom_range(0, 9) == 0));
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
